// File: rtl/skdecode_unpack_buffer.sv
// Secret-key unpack buffer: turns a 32-bit LSB-first word stream into S1/S2 (24-bit) and T0 (52-bit) chunks.
// Optional protocol checker enabled by defining SKDEC_UNPACK_PROTO_CHK_EN.
module skdecode_unpack_buffer #(
    parameter int L = 7,
    parameter int K = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        zeroize,
    input  logic        start,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        dout_valid,
    output logic [51:0] dout_data,
    input  logic        dout_ready,
    output logic [1:0]  dout_mode,
    output logic        done,
    output logic        error
);

    // State encoding doubles as dout_mode.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_T0   = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(K * 64 + 1);
    localparam logic [CNT_W-1:0] S1_LAST = CNT_W'(L * 32 - 1);
    localparam logic [CNT_W-1:0] S2_LAST = CNT_W'(K * 32 - 1);
    localparam logic [CNT_W-1:0] T0_LAST = CNT_W'(K * 64 - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [95:0]      buf_q, buf_d;
    logic [6:0]       occ_q, occ_d;

    logic             active, is_t0, chunk_rdy, src_acc, dout_hs, last_chunk;
    logic [6:0]       width, occ_sh;
    logic [95:0]      buf_sh;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        active     = (state_q != ST_IDLE);
        is_t0      = (state_q == ST_T0);
        width      = is_t0 ? 7'd52 : 7'd24;
        chunk_rdy  = active && (occ_q >= width);
        src_ready  = active && (occ_q <= 7'd64);
        src_acc    = src_valid && src_ready;
        dout_hs    = chunk_rdy && dout_ready;
        case (state_q)
            ST_S1:   last_cnt = S1_LAST;
            ST_S2:   last_cnt = S2_LAST;
            default: last_cnt = T0_LAST;
        endcase
        last_chunk = (cnt_q == last_cnt);
    end

    // Consume first, then append the new word right above what remains, so a
    // simultaneous accept on both sides lands at (occupancy - width).
    always_comb begin
        buf_sh = buf_q;
        occ_sh = occ_q;
        if (dout_hs) begin
            buf_sh = is_t0 ? (buf_q >> 52) : (buf_q >> 24);
            occ_sh = occ_q - width;
        end
        buf_d = buf_sh;
        occ_d = occ_sh;
        if (src_acc) begin
            buf_d = buf_sh | ({64'd0, src_data} << occ_sh);
            occ_d = occ_sh + 7'd32;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_S1;
                cnt_d   = '0;
            end
        end else if (dout_hs) begin
            if (last_chunk) begin
                cnt_d = '0;
                case (state_q)
                    ST_S1:   state_d = ST_S2;
                    ST_S2:   state_d = ST_T0;
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (zeroize) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            buf_d   = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            occ_q   <= occ_d;
        end
    end

    // Bits above occupancy are always zero, so the chunk view needs no masking.
    assign dout_valid = chunk_rdy;
    assign dout_data  = is_t0 ? buf_q[51:0] : {28'd0, buf_q[23:0]};
    assign dout_mode  = state_q;
    assign done       = is_t0 && dout_hs && last_chunk && !zeroize;

`ifdef SKDEC_UNPACK_PROTO_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = ((state_q == ST_IDLE) && src_valid) || ((state_q != ST_IDLE) && start);
        if (zeroize) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule
